// File: rtl/hart_debug_pkg.sv
// Shared types and dmstatus field positions for the hart-side debug responder and the
// dmcontrol decoder.
package hart_debug_pkg;

    typedef enum logic [2:0] {
        StRunning   = 3'd0,
        StHaltReq   = 3'd1,
        StHalted    = 3'd2,
        StResumeReq = 3'd3,
        StHartRst   = 3'd4,
        StUnavail   = 3'd5
    } state_e;

    localparam int unsigned IMPEBREAK       = 22;
    localparam int unsigned HAVERESET_ALL   = 19;
    localparam int unsigned HAVERESET_ANY   = 18;
    localparam int unsigned RESUMEACK_ALL   = 17;
    localparam int unsigned RESUMEACK_ANY   = 16;
    localparam int unsigned NONEXISTENT_ALL = 15;
    localparam int unsigned NONEXISTENT_ANY = 14;
    localparam int unsigned UNAVAIL_ALL     = 13;
    localparam int unsigned UNAVAIL_ANY     = 12;
    localparam int unsigned RUNNING_ALL     = 11;
    localparam int unsigned RUNNING_ANY     = 10;
    localparam int unsigned HALTED_ALL      = 9;
    localparam int unsigned HALTED_ANY      = 8;
    localparam int unsigned AUTHENTICATED   = 7;
    localparam int unsigned VERSION_MSB     = 3;
    localparam int unsigned VERSION_LSB     = 0;

    // A zero timeout still needs a one-bit timer so the register exists.
    function automatic int unsigned timer_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/hart_debug_ctrl_if.sv
// Decoded dmcontrol requests, core handshake and dmstatus word for one hart.
interface hart_debug_ctrl_if;

    logic        dmactive_i;
    logic        haltreq_i;
    logic        resumereq_i;
    logic        hartreset_i;
    logic        ndmreset_i;
    logic        ackhavereset_i;
    logic        setresethaltreq_i;
    logic        clrresethaltreq_i;
    logic        core_halted_i;
    logic        core_running_i;
    logic        core_debug_req_o;
    logic        core_resume_req_o;
    logic        core_reset_o;
    logic [31:0] dmstatus_o;

    modport slave (
        input  dmactive_i, haltreq_i, resumereq_i, hartreset_i, ndmreset_i,
        input  ackhavereset_i, setresethaltreq_i, clrresethaltreq_i,
        input  core_halted_i, core_running_i,
        output core_debug_req_o, core_resume_req_o, core_reset_o, dmstatus_o
    );

    modport master (
        output dmactive_i, haltreq_i, resumereq_i, hartreset_i, ndmreset_i,
        output ackhavereset_i, setresethaltreq_i, clrresethaltreq_i,
        output core_halted_i, core_running_i,
        input  core_debug_req_o, core_resume_req_o, core_reset_o, dmstatus_o
    );

endinterface

// File: rtl/hart_debug_ctrl.sv
// Hart-side halt/resume/reset responder to dmcontrol requests; reports dmstatus for one hart.
module hart_debug_ctrl
    import hart_debug_pkg::*;
#(
    parameter int unsigned HALT_TIMEOUT = 1024,
    parameter logic [3:0]  DM_VERSION   = 4'd3
) (
    input logic         clk_i,
    input logic         rst_ni,
    hart_debug_ctrl_if.slave dbg
);

    localparam int unsigned         TimerW      = timer_width(HALT_TIMEOUT);
    localparam bit                  TimeoutOn   = (HALT_TIMEOUT != 0);
    localparam logic [TimerW-1:0]   TimeoutLast =
        TimerW'((HALT_TIMEOUT == 0) ? 0 : HALT_TIMEOUT - 1);
    localparam logic [TimerW-1:0]   TimerMax    = '1;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic                havereset_q, havereset_d;
    logic                resumeack_q, resumeack_d;
    logic                unavail_q, unavail_d;
    logic                resethalt_q, resethalt_d;
    logic                debug_req_q, resume_req_q, reset_req_q;
    logic                any_reset;

    assign any_reset = dbg.hartreset_i | dbg.ndmreset_i;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        havereset_d = havereset_q;
        resumeack_d = resumeack_q;
        unavail_d   = unavail_q;
        resethalt_d = resethalt_q;

        if (dbg.ackhavereset_i)    havereset_d = 1'b0;
        if (dbg.setresethaltreq_i) resethalt_d = 1'b1;
        if (dbg.clrresethaltreq_i) resethalt_d = 1'b0;

        if (any_reset) begin
            state_d     = StHartRst;
            havereset_d = 1'b1;
            timer_d     = '0;
        end else if (!dbg.dmactive_i) begin
            // DM held in reset: drop per-session status but keep the havereset sticky bit.
            resumeack_d = 1'b0;
            unavail_d   = 1'b0;
            resethalt_d = 1'b0;
            timer_d     = '0;
            state_d     = dbg.core_halted_i ? StHalted : StRunning;
        end else begin
            unique case (state_q)
                StHartRst: state_d = resethalt_q ? StHaltReq : StRunning;
                StRunning: begin
                    if (dbg.haltreq_i) begin
                        state_d = StHaltReq;
                        timer_d = '0;
                    end else if (dbg.core_halted_i) begin
                        state_d = StHalted;
                    end
                end
                StHaltReq: begin
                    if (dbg.core_halted_i) begin
                        state_d = StHalted;
                    end else begin
                        if (timer_q != TimerMax) timer_d = timer_q + TimerW'(1);
                        if (TimeoutOn && (timer_q == TimeoutLast)) begin
                            state_d   = StUnavail;
                            unavail_d = 1'b1;
                        end
                    end
                end
                StHalted: begin
                    if (dbg.resumereq_i && !dbg.haltreq_i) begin
                        state_d     = StResumeReq;
                        resumeack_d = 1'b0;
                    end
                end
                StResumeReq: begin
                    if (dbg.core_running_i && !dbg.core_halted_i) begin
                        state_d     = StRunning;
                        resumeack_d = 1'b1;
                    end
                end
                StUnavail: state_d = StUnavail;
                default:   state_d = StRunning;
            endcase
        end
    end

    // Core-facing outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StRunning;
            timer_q      <= '0;
            havereset_q  <= 1'b1;
            resumeack_q  <= 1'b0;
            unavail_q    <= 1'b0;
            resethalt_q  <= 1'b0;
            debug_req_q  <= 1'b0;
            resume_req_q <= 1'b0;
            reset_req_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            havereset_q  <= havereset_d;
            resumeack_q  <= resumeack_d;
            unavail_q    <= unavail_d;
            resethalt_q  <= resethalt_d;
            debug_req_q  <= (state_d == StHaltReq);
            resume_req_q <= (state_d == StResumeReq);
            reset_req_q  <= (state_d == StHartRst);
        end
    end

    assign dbg.core_debug_req_o  = debug_req_q;
    assign dbg.core_resume_req_o = resume_req_q;
    assign dbg.core_reset_o      = reset_req_q;

    logic [31:0] dmstatus;
    logic        unavail_flag;

    assign unavail_flag = unavail_q | (state_q == StHartRst);

    always_comb begin
        dmstatus                          = '0;
        dmstatus[IMPEBREAK]               = 1'b0;
        dmstatus[HAVERESET_ALL]           = havereset_q;
        dmstatus[HAVERESET_ANY]           = havereset_q;
        dmstatus[RESUMEACK_ALL]           = resumeack_q;
        dmstatus[RESUMEACK_ANY]           = resumeack_q;
        dmstatus[NONEXISTENT_ALL]         = 1'b0;
        dmstatus[NONEXISTENT_ANY]         = 1'b0;
        dmstatus[UNAVAIL_ALL]             = unavail_flag;
        dmstatus[UNAVAIL_ANY]             = unavail_flag;
        dmstatus[RUNNING_ALL]             = (state_q == StRunning);
        dmstatus[RUNNING_ANY]             = (state_q == StRunning);
        dmstatus[HALTED_ALL]              = (state_q == StHalted);
        dmstatus[HALTED_ANY]              = (state_q == StHalted);
        dmstatus[AUTHENTICATED]           = 1'b1;
        dmstatus[VERSION_MSB:VERSION_LSB] = DM_VERSION;
    end

    assign dbg.dmstatus_o = dmstatus;

endmodule

// File: tb/tb_hart_debug_ctrl.sv
// Directed bench for hart_debug_ctrl: halt, resume, reset handshakes, timeout, async reset.
module tb_hart_debug_ctrl;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;

    hart_debug_ctrl_if dbg ();

    hart_debug_ctrl #(
        .HALT_TIMEOUT (8),
        .DM_VERSION   (4'd3)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .dbg    (dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        compared++;
        if (dbg.core_debug_req_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_debug_req: got %b want 0", dbg.core_debug_req_o);
        end
        compared++;
        if ({dbg.core_resume_req_o, dbg.core_reset_o} !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_resume_reset: got %b want 00",
                     {dbg.core_resume_req_o, dbg.core_reset_o});
        end
        compared++;
        if (dbg.dmstatus_o !== 32'h000C_0C83) begin
            mismatched++;
            $display("FAIL reset_dmstatus: got %h want 000c0c83", dbg.dmstatus_o);
        end
    endtask

    task automatic test_ackhavereset();
        @(negedge clk);
        dbg.ackhavereset_i = 1'b1;
        @(negedge clk);
        dbg.ackhavereset_i = 1'b0;
        compared++;
        if (dbg.dmstatus_o !== 32'h0000_0C83) begin
            mismatched++;
            $display("FAIL ack_dmstatus: got %h want 00000c83", dbg.dmstatus_o);
        end
    endtask

    task automatic test_halt();
        int cnt = 0;
        @(negedge clk);
        dbg.haltreq_i = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) dbg.haltreq_i = 1'b0;
            if (dbg.core_debug_req_o === 1'b1) cnt++;
            if (i == 3) begin
                dbg.core_halted_i  = 1'b1;
                dbg.core_running_i = 1'b0;
            end
        end
        compared++;
        if (cnt !== 3) begin
            mismatched++;
            $display("FAIL halt_req_cycles: got %0d want 3", cnt);
        end
        compared++;
        if (dbg.dmstatus_o[9:8] !== 2'b11) begin
            mismatched++;
            $display("FAIL halt_halted: got %b want 11", dbg.dmstatus_o[9:8]);
        end
        compared++;
        if (dbg.dmstatus_o[11:10] !== 2'b00) begin
            mismatched++;
            $display("FAIL halt_running: got %b want 00", dbg.dmstatus_o[11:10]);
        end
    endtask

    task automatic test_resume();
        int cnt = 0;
        @(negedge clk);
        dbg.resumereq_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                dbg.resumereq_i = 1'b0;
                compared++;
                if (dbg.dmstatus_o[17:16] !== 2'b00) begin
                    mismatched++;
                    $display("FAIL resume_ack_cleared: got %b want 00", dbg.dmstatus_o[17:16]);
                end
            end
            if (dbg.core_resume_req_o === 1'b1) cnt++;
            if (i == 2) begin
                dbg.core_halted_i  = 1'b0;
                dbg.core_running_i = 1'b1;
            end
        end
        compared++;
        if (cnt !== 2) begin
            mismatched++;
            $display("FAIL resume_req_cycles: got %0d want 2", cnt);
        end
        compared++;
        if (dbg.dmstatus_o[17:10] !== 8'b1100_0011) begin
            mismatched++;
            $display("FAIL resume_status: got %b want 11000011", dbg.dmstatus_o[17:10]);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        dbg.haltreq_i = 1'b1;
        @(negedge clk);
        dbg.haltreq_i      = 1'b0;
        dbg.core_halted_i  = 1'b1;
        dbg.core_running_i = 1'b0;
        @(negedge clk);
        dbg.haltreq_i   = 1'b1;
        dbg.resumereq_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            compared++;
            if (dbg.dmstatus_o[9:8] !== 2'b11) begin
                mismatched++;
                $display("FAIL both_req_halted: got %b want 11", dbg.dmstatus_o[9:8]);
            end
            compared++;
            if (dbg.core_resume_req_o !== 1'b0) begin
                mismatched++;
                $display("FAIL both_req_resume: got %b want 0", dbg.core_resume_req_o);
            end
        end
        dbg.haltreq_i      = 1'b0;
        dbg.resumereq_i    = 1'b0;
        dbg.ackhavereset_i = 1'b1;
        dbg.ndmreset_i     = 1'b1;
        @(negedge clk);
        dbg.ackhavereset_i = 1'b0;
        dbg.ndmreset_i     = 1'b0;
        dbg.core_halted_i  = 1'b0;
        dbg.core_running_i = 1'b1;
        compared++;
        if (dbg.dmstatus_o[19:18] !== 2'b11) begin
            mismatched++;
            $display("FAIL ack_vs_ndmreset: got %b want 11", dbg.dmstatus_o[19:18]);
        end
        compared++;
        if (dbg.core_reset_o !== 1'b1) begin
            mismatched++;
            $display("FAIL ndmreset_core_reset: got %b want 1", dbg.core_reset_o);
        end
        @(negedge clk);
        compared++;
        if (dbg.dmstatus_o[11:10] !== 2'b11) begin
            mismatched++;
            $display("FAIL ndmreset_release_running: got %b want 11", dbg.dmstatus_o[11:10]);
        end
    endtask

    task automatic test_reset_halt();
        int cnt = 0;
        @(negedge clk);
        dbg.ackhavereset_i = 1'b1;
        @(negedge clk);
        dbg.ackhavereset_i = 1'b0;
        compared++;
        if (dbg.dmstatus_o[19:18] !== 2'b00) begin
            mismatched++;
            $display("FAIL rh_ack: got %b want 00", dbg.dmstatus_o[19:18]);
        end
        dbg.setresethaltreq_i = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                dbg.setresethaltreq_i = 1'b0;
                dbg.hartreset_i       = 1'b1;
            end
            if (i == 5) dbg.hartreset_i = 1'b0;
            if (dbg.core_reset_o === 1'b1) cnt++;
            if (i == 2) begin
                compared++;
                if (dbg.dmstatus_o[13:12] !== 2'b11) begin
                    mismatched++;
                    $display("FAIL rh_unavail_in_reset: got %b want 11", dbg.dmstatus_o[13:12]);
                end
            end
        end
        compared++;
        if (cnt !== 4) begin
            mismatched++;
            $display("FAIL rh_reset_cycles: got %0d want 4", cnt);
        end
        compared++;
        if (dbg.core_debug_req_o !== 1'b1) begin
            mismatched++;
            $display("FAIL rh_halt_req: got %b want 1", dbg.core_debug_req_o);
        end
        compared++;
        if (dbg.dmstatus_o[19:18] !== 2'b11) begin
            mismatched++;
            $display("FAIL rh_havereset: got %b want 11", dbg.dmstatus_o[19:18]);
        end
        // Finish the halt, then resume back to RUNNING for the next scenario.
        dbg.core_halted_i  = 1'b1;
        dbg.core_running_i = 1'b0;
        @(negedge clk);
        dbg.resumereq_i = 1'b1;
        @(negedge clk);
        dbg.resumereq_i    = 1'b0;
        dbg.core_halted_i  = 1'b0;
        dbg.core_running_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int cnt = 0;
        @(negedge clk);
        dbg.haltreq_i = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (dbg.core_debug_req_o === 1'b1) cnt++;
        end
        dbg.haltreq_i = 1'b0;
        compared++;
        if (cnt !== 8) begin
            mismatched++;
            $display("FAIL to_req_cycles: got %0d want 8", cnt);
        end
        compared++;
        if (dbg.dmstatus_o[13:8] !== 6'b110000) begin
            mismatched++;
            $display("FAIL to_status: got %b want 110000", dbg.dmstatus_o[13:8]);
        end
        dbg.dmactive_i = 1'b0;
        @(negedge clk);
        dbg.dmactive_i = 1'b1;
        compared++;
        if (dbg.dmstatus_o[13:12] !== 2'b00) begin
            mismatched++;
            $display("FAIL to_dmactive_clear: got %b want 00", dbg.dmstatus_o[13:12]);
        end
        compared++;
        if (dbg.dmstatus_o[11:10] !== 2'b11) begin
            mismatched++;
            $display("FAIL to_dmactive_running: got %b want 11", dbg.dmstatus_o[11:10]);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        dbg.haltreq_i = 1'b1;
        @(negedge clk);
        dbg.haltreq_i = 1'b0;
        compared++;
        if (dbg.core_debug_req_o !== 1'b1) begin
            mismatched++;
            $display("FAIL ar_pre_halt_req: got %b want 1", dbg.core_debug_req_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (dbg.core_debug_req_o !== 1'b0) begin
            mismatched++;
            $display("FAIL ar_debug_req: got %b want 0", dbg.core_debug_req_o);
        end
        compared++;
        if (dbg.dmstatus_o !== 32'h000C_0C83) begin
            mismatched++;
            $display("FAIL ar_dmstatus: got %h want 000c0c83", dbg.dmstatus_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        compared              = 0;
        mismatched            = 0;
        rst_n                 = 1'b0;
        dbg.dmactive_i        = 1'b1;
        dbg.haltreq_i         = 1'b0;
        dbg.resumereq_i       = 1'b0;
        dbg.hartreset_i       = 1'b0;
        dbg.ndmreset_i        = 1'b0;
        dbg.ackhavereset_i    = 1'b0;
        dbg.setresethaltreq_i = 1'b0;
        dbg.clrresethaltreq_i = 1'b0;
        dbg.core_halted_i     = 1'b0;
        dbg.core_running_i    = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_ackhavereset();
        test_halt();
        test_resume();
        test_simultaneous();
        test_reset_halt();
        test_timeout();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hart_debug_ctrl.md
Name: hart_debug_ctrl

Overview:
- Hart-side responder to the debug module's dmcontrol requests for a single hart.
- Consumes the decoded dmcontrol fields (haltreq, resumereq, hartreset, ackhavereset, set/clrresethaltreq, ndmreset, dmactive).
- Runs the halt/resume/reset handshake with the core.
- Returns the dmstatus word to the DM register file for debugger reads.

Parameters:
- HALT_TIMEOUT, 1024: cycles allowed in HALT_REQ before the hart is flagged unavailable; 0 disables the timeout.
- DM_VERSION, 4'd3: dmstatus.version field (3 = debug spec 1.0).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- dmactive_i  input  1  DM active; 0 = DM held in reset
- haltreq_i  input  1  level halt request
- resumereq_i  input  1  resume request
- hartreset_i  input  1  hart reset request (level)
- ndmreset_i  input  1  non-debug-module system reset (level)
- ackhavereset_i  input  1  clears havereset
- setresethaltreq_i  input  1  arms halt-on-reset
- clrresethaltreq_i  input  1  disarms halt-on-reset
- core_halted_i  input  1  core is in debug mode
- core_running_i  input  1  core is executing normally
- core_debug_req_o  output  1  debug-entry request to the core
- core_resume_req_o  output  1  resume request to the core
- core_reset_o  output  1  hart reset to the core
- dmstatus_o  output  32  dmstatus word

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=RUNNING, havereset_q=1, resumeack_q=0, unavail_q=0, resethalt_q=0, timer=0.
  - All core_* outputs are 0.
- FSM states: RUNNING, HALT_REQ, HALTED, RESUME_REQ, HART_RST, UNAVAIL.
- Moore outputs, all decoded from registered state. An input sampled at edge N is reflected on the outputs after edge N, i.e. 1-cycle latency.
- core_debug_req_o = (state==HALT_REQ).
- core_resume_req_o = (state==RESUME_REQ).
- core_reset_o = (state==HART_RST).
- Priority per cycle, highest first:
  1. (hartreset_i|ndmreset_i) -> HART_RST; havereset_q<=1; timer<=0.
  2. dmactive_i=0:
     - resumeack_q, unavail_q, resethalt_q, timer <= 0.
     - state <= HALTED if core_halted_i, else RUNNING.
     - havereset_q is kept.
  3. Normal transitions below.
- HART_RST:
  - Stay while either reset input is high.
  - On release: -> HALT_REQ if resethalt_q, else RUNNING.
- RUNNING:
  - haltreq_i -> HALT_REQ, timer<=0.
  - core_halted_i without a request (e.g. ebreak) -> HALTED.
- HALT_REQ:
  - core_halted_i -> HALTED.
  - Otherwise timer++.
  - When HALT_TIMEOUT!=0 and timer==HALT_TIMEOUT-1 -> UNAVAIL, unavail_q<=1.
- HALTED:
  - resumereq_i & ~haltreq_i -> RESUME_REQ, resumeack_q<=0.
  - haltreq_i wins when both requests are high; resumereq_i is then ignored.
- RESUME_REQ:
  - core_running_i & ~core_halted_i -> RUNNING, resumeack_q<=1.
  - No timeout in this state.
- UNAVAIL: exits only via priority 1 or 2.
- Side registers:
  - ackhavereset_i clears havereset_q unless priority 1 is active in the same cycle, in which case set wins.
  - setresethaltreq_i sets resethalt_q; clrresethaltreq_i clears it; clear wins when both are high.
- Timer width is $clog2(HALT_TIMEOUT+1), minimum 1 bit; saturates, never wraps.
- dmstatus_o, combinational from registers. Single hart, so every all*/any* pair carries the same value:
  - [19]/[18] havereset_q
  - [17]/[16] resumeack_q
  - [15]/[14] 0 (nonexistent)
  - [13]/[12] unavail_q | (state==HART_RST)
  - [11]/[10] state==RUNNING
  - [9]/[8] state==HALTED
  - [7] authenticated=1
  - [22] impebreak=0
  - [3:0] DM_VERSION
  - all other bits 0

Decomposition:
- Package hart_debug_pkg holds:
  - state enum localparams.
  - dmstatus bit-index localparams (HAVERESET_ALL=19 ... VERSION_LSB=0).
- The dmcontrol decoder imports the same package.
- No sub-module: the FSM, side registers and timer fit one module. The dmstatus packing stays inline.

Test Plan:
- Halt: power-on reset, dmactive_i=1, haltreq_i=1 for 1 cycle, core_halted_i=1 three cycles later.
  -> core_debug_req_o high for exactly 3 cycles.
  -> dmstatus_o[9:8]=2'b11, [11:10]=2'b00.
- Resume: from HALTED, resumereq_i=1, core_running_i=1 two cycles later.
  -> core_resume_req_o high for 2 cycles.
  -> dmstatus_o[17:16]=2'b11 and [11:10]=2'b11 in the following cycle.
- havereset and reset-halt: after reset dmstatus_o[19:18]=2'b11; ackhavereset_i pulse -> 2'b00. Then setresethaltreq_i, hartreset_i high 4 cycles then low.
  -> core_reset_o high 4 cycles.
  -> FSM enters HALT_REQ.
  -> [19:18]=2'b11 again.
- Timeout: HALT_TIMEOUT=8, haltreq_i=1, core never halts.
  -> core_debug_req_o high exactly 8 cycles.
  -> dmstatus_o[13:12]=2'b11.
  -> dmactive_i=0 for one cycle clears [13:12] to 2'b00.
- Simultaneous: in HALTED assert haltreq_i and resumereq_i together -> stays HALTED, core_resume_req_o stays 0. In the same cycle pulse ackhavereset_i and ndmreset_i -> havereset stays 1.
- Async reset mid-operation: drop rst_ni in HALT_REQ between clock edges -> core_debug_req_o=0 immediately, state RUNNING, dmstatus_o=0x000C_0C83.
